// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Optional build macro: PC_SEQ_RETIRE_CNT_EN (adds a retired-instruction counter).
package pc_seq_pkg;

    localparam int ADDR_W_DEF      = 8;
    localparam int STACK_DEPTH_DEF = 4;

    localparam int PRIO_INC    = 0;
    localparam int PRIO_BRANCH = 1;
    localparam int PRIO_CALL   = 2;
    localparam int PRIO_RET    = 3;
    localparam int PRIO_HALT   = 4;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_HALTED,
        ST_FAULT
    } state_t;

    typedef enum logic [2:0] {
        ACT_INC    = 3'(PRIO_INC),
        ACT_BRANCH = 3'(PRIO_BRANCH),
        ACT_CALL   = 3'(PRIO_CALL),
        ACT_RET    = 3'(PRIO_RET),
        ACT_HALT   = 3'(PRIO_HALT)
    } act_t;

    // Highest-priority decoder request wins; untaken branch is a plain step.
    function automatic act_t resolve(
        input logic halt,
        input logic ret,
        input logic call,
        input logic br,
        input logic taken
    );
        act_t a;
        if (halt)            a = ACT_HALT;
        else if (ret)        a = ACT_RET;
        else if (call)       a = ACT_CALL;
        else if (br && taken) a = ACT_BRANCH;
        else                 a = ACT_INC;
        return a;
    endfunction

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Return-address LIFO; push and pop are never asserted together.
// Only the occupancy counter is reset, so stale entries are simply unreachable.
module return_stack #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int LW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  top,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
        end else if (push) begin
            level <= level + LW'(1);
        end else if (pop) begin
            level <= level - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[level[PW-1:0]] <= din;
        end
    end

    assign top   = mem[PW'(level - LW'(1))];
    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/pc_sequencer.sv
// FETCH/EXEC sequencer driving PC en/overwrite, with a hardware return stack.
// Optional build macro: PC_SEQ_RETIRE_CNT_EN adds the retired_cnt output.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF,
    localparam int LVL_W      = $clog2(STACK_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic              stall,
    input  logic              branch_req,
    input  logic              branch_taken,
    input  logic              call_req,
    input  logic              ret_req,
    input  logic              halt_req,
    input  logic              resume,
    input  logic [ADDR_W-1:0] target,
    output logic              pc_en,
    output logic              pc_overwrite,
    output logic [ADDR_W-1:0] pc_overwrite_data,
    output logic              halted,
    output logic              stack_fault,
    output logic [LVL_W-1:0]  stack_level
`ifdef PC_SEQ_RETIRE_CNT_EN
    ,
    output logic [15:0]       retired_cnt
`endif
);

    state_t            state, next_state;
    act_t              act;
    logic              push, pop;
    logic              full, empty;
    logic [ADDR_W-1:0] top;
    logic              fault_q;

    return_stack #(
        .W     (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (pc_addr + ADDR_W'(1)),
        .top   (top),
        .full  (full),
        .empty (empty),
        .level (stack_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_FETCH;
            fault_q <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == ST_FAULT) begin
                fault_q <= 1'b1;
            end
        end
    end

    assign act = resolve(halt_req, ret_req, call_req,
                         branch_req, branch_taken);

    // Controls are Mealy in EXEC so the PC moves on the edge leaving EXEC.
    always_comb begin
        next_state        = state;
        pc_en             = 1'b0;
        pc_overwrite      = 1'b0;
        pc_overwrite_data = '0;
        push              = 1'b0;
        pop               = 1'b0;
        unique case (state)
            ST_FETCH: next_state = ST_EXEC;
            ST_EXEC: begin
                if (!stall) begin
                    unique case (act)
                        ACT_HALT: next_state = ST_HALTED;
                        ACT_RET: begin
                            if (empty) begin
                                next_state = ST_FAULT;
                            end else begin
                                pc_overwrite      = 1'b1;
                                pc_overwrite_data = top;
                                pop               = 1'b1;
                                next_state        = ST_FETCH;
                            end
                        end
                        ACT_CALL: begin
                            if (full) begin
                                next_state = ST_FAULT;
                            end else begin
                                pc_overwrite      = 1'b1;
                                pc_overwrite_data = target;
                                push              = 1'b1;
                                next_state        = ST_FETCH;
                            end
                        end
                        ACT_BRANCH: begin
                            pc_overwrite      = 1'b1;
                            pc_overwrite_data = target;
                            next_state        = ST_FETCH;
                        end
                        ACT_INC: begin
                            pc_en      = 1'b1;
                            next_state = ST_FETCH;
                        end
                        default: next_state = ST_FETCH;
                    endcase
                end
            end
            ST_HALTED: begin
                if (resume) begin
                    next_state = ST_FETCH;
                end
            end
            ST_FAULT: next_state = ST_FAULT;
            default:  next_state = ST_FETCH;
        endcase
    end

    assign halted      = (state == ST_HALTED);
    assign stack_fault = fault_q;

`ifdef PC_SEQ_RETIRE_CNT_EN
    logic retire;

    assign retire = (state == ST_EXEC) && !stall &&
                    ((next_state == ST_FETCH) ||
                     (next_state == ST_HALTED));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_cnt <= '0;
        end else if (retire && (retired_cnt != 16'hFFFF)) begin
            retired_cnt <= retired_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with a behavioural 8-bit PC.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pc;
    logic       stall = 0, branch_req = 0, branch_taken = 0;
    logic       call_req = 0, ret_req = 0, halt_req = 0, resume = 0;
    logic [7:0] target = 8'h00;
    logic       pc_en, pc_overwrite, halted, stack_fault;
    logic [7:0] pc_overwrite_data;
    logic [2:0] stack_level;
`ifdef PC_SEQ_RETIRE_CNT_EN
    logic [15:0] retired_cnt;
`endif
    int checks = 0;
    int errors = 0;

    pc_sequencer dut (
        .clk               (clk),
        .rst               (rst),
        .pc_addr           (pc),
        .stall             (stall),
        .branch_req        (branch_req),
        .branch_taken      (branch_taken),
        .call_req          (call_req),
        .ret_req           (ret_req),
        .halt_req          (halt_req),
        .resume            (resume),
        .target            (target),
        .pc_en             (pc_en),
        .pc_overwrite      (pc_overwrite),
        .pc_overwrite_data (pc_overwrite_data),
        .halted            (halted),
        .stack_fault       (stack_fault),
        .stack_level       (stack_level)
`ifdef PC_SEQ_RETIRE_CNT_EN
        ,
        .retired_cnt       (retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (rst) pc <= 8'h00;
        else if (pc_overwrite) pc <= pc_overwrite_data;
        else if (pc_en) pc <= pc + 8'h01;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic clear_reqs();
        stall = 0; branch_req = 0; branch_taken = 0;
        call_req = 0; ret_req = 0; halt_req = 0; resume = 0;
    endtask

    // From a FETCH-cycle negedge, move to the EXEC-cycle negedge.
    task automatic enter_exec();
        @(negedge clk);
    endtask

    task automatic leave_exec();
        @(negedge clk);
        clear_reqs();
    endtask

    task automatic do_call(input logic [7:0] t);
        enter_exec();
        call_req = 1; target = t;
        leave_exec();
    endtask

    task automatic do_reset();
        rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        call_req = 1; target = 8'h55;
        @(negedge clk); #1;
        checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL rst_en got %0h exp 0", pc_en); end
        checks++; if (pc_overwrite !== 1'b0) begin errors++; $display("FAIL rst_ow got %0h exp 0", pc_overwrite); end
        checks++; if (pc_overwrite_data !== 8'h00) begin errors++; $display("FAIL rst_data got %0h exp 0", pc_overwrite_data); end
        checks++; if ({halted, stack_fault, stack_level} !== 5'b0) begin errors++; $display("FAIL rst_status got %0h exp 0", {halted, stack_fault, stack_level}); end
        clear_reqs();
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++; if (pc_en !== 1'(i % 2)) begin errors++; $display("FAIL seq_en%0d got %0h exp %0h", i, pc_en, i % 2); end
            @(negedge clk);
        end
        checks++; if (pc !== 8'h03) begin errors++; $display("FAIL seq_pc got %0h exp 3", pc); end
    endtask

    task automatic test_branch();
        enter_exec();
        branch_req = 1; branch_taken = 1; target = 8'h40; #1;
        checks++; if ({pc_overwrite, pc_en} !== 2'b10) begin errors++; $display("FAIL br_ctl got %0b exp 10", {pc_overwrite, pc_en}); end
        checks++; if (pc_overwrite_data !== 8'h40) begin errors++; $display("FAIL br_data got %0h exp 40", pc_overwrite_data); end
        leave_exec(); #1;
        checks++; if (pc !== 8'h40) begin errors++; $display("FAIL br_pc got %0h exp 40", pc); end
        checks++; if (pc_overwrite !== 1'b0) begin errors++; $display("FAIL br_fetch_ow got %0h exp 0", pc_overwrite); end
        enter_exec();
        branch_req = 1; branch_taken = 0; target = 8'h77; #1;
        checks++; if ({pc_overwrite, pc_en} !== 2'b01) begin errors++; $display("FAIL nbr_ctl got %0b exp 01", {pc_overwrite, pc_en}); end
        leave_exec();
        checks++; if (pc !== 8'h41) begin errors++; $display("FAIL nbr_pc got %0h exp 41", pc); end
    endtask

    task automatic test_call_ret();
        logic [7:0] exp_ret [3];
        exp_ret = '{8'h31, 8'h21, 8'h11};
        enter_exec();
        branch_req = 1; branch_taken = 1; target = 8'h10;
        leave_exec();
        enter_exec();
        call_req = 1; target = 8'h20; #1;
        checks++; if ({pc_overwrite, pc_en, pc_overwrite_data} !== {2'b10, 8'h20}) begin errors++; $display("FAIL call_ctl got %0h exp 220", {pc_overwrite, pc_en, pc_overwrite_data}); end
        leave_exec();
        checks++; if (stack_level !== 3'd1) begin errors++; $display("FAIL call_lvl1 got %0d exp 1", stack_level); end
        do_call(8'h30);
        do_call(8'h50);
        checks++; if (stack_level !== 3'd3) begin errors++; $display("FAIL call_lvl3 got %0d exp 3", stack_level); end
        checks++; if (pc !== 8'h50) begin errors++; $display("FAIL call_pc got %0h exp 50", pc); end
        for (int i = 0; i < 3; i++) begin
            enter_exec();
            ret_req = 1; #1;
            checks++; if ({pc_overwrite, pc_overwrite_data} !== {1'b1, exp_ret[i]}) begin errors++; $display("FAIL ret%0d got %0h exp %0h", i, {pc_overwrite, pc_overwrite_data}, {1'b1, exp_ret[i]}); end
            leave_exec();
        end
        checks++; if (stack_level !== 3'd0) begin errors++; $display("FAIL ret_lvl got %0d exp 0", stack_level); end
        checks++; if (pc !== 8'h11) begin errors++; $display("FAIL ret_pc got %0h exp 11", pc); end
    endtask

    task automatic test_wrap_fault();
        enter_exec();
        branch_req = 1; branch_taken = 1; target = 8'hFF;
        leave_exec();
        do_call(8'h80);
        enter_exec();
        ret_req = 1; #1;
        checks++; if (pc_overwrite_data !== 8'h00) begin errors++; $display("FAIL wrap_ret got %0h exp 00", pc_overwrite_data); end
        leave_exec();
        do_call(8'h10);
        do_call(8'h20);
        do_call(8'h30);
        do_call(8'h40);
        checks++; if (stack_level !== 3'd4) begin errors++; $display("FAIL full_lvl got %0d exp 4", stack_level); end
        enter_exec();
        call_req = 1; target = 8'h99; #1;
        checks++; if ({pc_overwrite, pc_en} !== 2'b00) begin errors++; $display("FAIL ovf_ctl got %0b exp 00", {pc_overwrite, pc_en}); end
        leave_exec(); #1;
        checks++; if (stack_fault !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0h exp 1", stack_fault); end
        checks++; if (stack_level !== 3'd4) begin errors++; $display("FAIL ovf_lvl got %0d exp 4", stack_level); end
        checks++; if (pc !== 8'h40) begin errors++; $display("FAIL ovf_pc got %0h exp 40", pc); end
        resume = 1; branch_req = 1; branch_taken = 1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if ({stack_fault, halted, pc_overwrite, pc_en} !== 4'b1000) begin errors++; $display("FAIL fault_hold got %0b exp 1000", {stack_fault, halted, pc_overwrite, pc_en}); end
        clear_reqs();
        rst = 1; #1;
        checks++; if ({stack_fault, stack_level} !== 4'b0) begin errors++; $display("FAIL fault_clr got %0h exp 0", {stack_fault, stack_level}); end
        @(negedge clk);
        rst = 0;
        enter_exec();
        ret_req = 1; #1;
        checks++; if (pc_overwrite !== 1'b0) begin errors++; $display("FAIL udf_ow got %0h exp 0", pc_overwrite); end
        leave_exec(); #1;
        checks++; if ({stack_fault, stack_level} !== 4'b1000) begin errors++; $display("FAIL udf_flag got %0b exp 1000", {stack_fault, stack_level}); end
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL udf_pc got %0h exp 0", pc); end
        do_reset();
    endtask

    task automatic test_priority_stall();
        do_call(8'h08);
        enter_exec();
        halt_req = 1; call_req = 1; target = 8'h60; #1;
        checks++; if ({pc_overwrite, pc_en} !== 2'b00) begin errors++; $display("FAIL halt_ctl got %0b exp 00", {pc_overwrite, pc_en}); end
        leave_exec();
        checks++; if ({halted, stack_level} !== {1'b1, 3'd1}) begin errors++; $display("FAIL halt_state got %0h exp 9", {halted, stack_level}); end
        branch_req = 1; branch_taken = 1; call_req = 1; target = 8'h61; #1;
        checks++; if ({pc_overwrite, pc_en} !== 2'b00) begin errors++; $display("FAIL halt_ign got %0b exp 00", {pc_overwrite, pc_en}); end
        @(negedge clk);
        checks++; if ({halted, pc} !== {1'b1, 8'h08}) begin errors++; $display("FAIL halt_pc got %0h exp 108", {halted, pc}); end
        clear_reqs();
        resume = 1;
        @(negedge clk);
        resume = 0;
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL resume got %0h exp 0", halted); end
        enter_exec();
        stall = 1; branch_req = 1; branch_taken = 1; target = 8'h70;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({pc_overwrite, pc_en} !== 2'b00) begin errors++; $display("FAIL stall%0d got %0b exp 00", i, {pc_overwrite, pc_en}); end
            @(negedge clk);
        end
        stall = 0; #1;
        checks++; if ({pc_overwrite, pc_overwrite_data} !== {1'b1, 8'h70}) begin errors++; $display("FAIL unstall got %0h exp 170", {pc_overwrite, pc_overwrite_data}); end
        leave_exec();
        checks++; if (pc !== 8'h70) begin errors++; $display("FAIL unstall_pc got %0h exp 70", pc); end
    endtask

    task automatic test_async_reset();
        enter_exec();
        call_req = 1; target = 8'h22; #1;
        checks++; if (pc_overwrite !== 1'b1) begin errors++; $display("FAIL arst_pre got %0h exp 1", pc_overwrite); end
        #2 rst = 1; #1;
        checks++; if ({pc_overwrite, pc_en, stack_level} !== 5'b0) begin errors++; $display("FAIL arst_now got %0h exp 0", {pc_overwrite, pc_en, stack_level}); end
        @(negedge clk);
        checks++; if ({pc, stack_level} !== 11'b0) begin errors++; $display("FAIL arst_after got %0h exp 0", {pc, stack_level}); end
`ifdef PC_SEQ_RETIRE_CNT_EN
        checks++; if (retired_cnt !== 16'd0) begin errors++; $display("FAIL arst_cnt got %0d exp 0", retired_cnt); end
`endif
        rst = 0; clear_reqs();
        enter_exec(); #1;
        checks++; if (pc_en !== 1'b1) begin errors++; $display("FAIL arst_exec got %0h exp 1", pc_en); end
        leave_exec();
        checks++; if ({pc, stack_level} !== {8'h01, 3'd0}) begin errors++; $display("FAIL arst_pc got %0h exp 8", {pc, stack_level}); end
`ifdef PC_SEQ_RETIRE_CNT_EN
        checks++; if (retired_cnt !== 16'd1) begin errors++; $display("FAIL arst_cnt1 got %0d exp 1", retired_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_branch();
        test_call_ret();
        test_wrap_fault();
        test_priority_stall();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
